// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline control blocks.
package mips_pkg;

    // Encoding is visible to the rest of the core, so values are pinned.
    typedef enum logic {
        OCIOSO   = 1'b0,
        CONTANDO = 1'b1
    } estado_md_t;

    localparam int REG_W          = 5;
    localparam int BOLHAS_W       = 16;
    localparam int LAT_MUL_PADRAO = 4;
    localparam int LAT_DIV_PADRAO = 32;

endpackage

// File: rtl/controle_hazard_if.sv
// Hazard-control bundle between the pipeline datapath and controle_hazard.
interface controle_hazard_if;

    logic [mips_pkg::REG_W-1:0]    id_rs;
    logic [mips_pkg::REG_W-1:0]    id_rt;
    logic                          id_usa_rs;
    logic                          id_usa_rt;
    logic                          id_inicia_mul;
    logic                          id_inicia_div;
    logic                          id_le_hilo;
    logic                          ex_le_mem;
    logic [mips_pkg::REG_W-1:0]    ex_rt;
    logic                          ex_desvio_tomado;

    logic                          pc_escrita;
    logic                          if_id_parada;
    logic                          if_id_limpar;
    logic                          id_ex_limpar;
    logic                          muldiv_inicia;
    logic                          muldiv_ocupado;
    logic [mips_pkg::BOLHAS_W-1:0] contador_bolhas;

    // Pipeline side: reports ID/EX contents, obeys the stall/flush controls.
    modport master (
        output id_rs, id_rt, id_usa_rs, id_usa_rt,
               id_inicia_mul, id_inicia_div, id_le_hilo,
               ex_le_mem, ex_rt, ex_desvio_tomado,
        input  pc_escrita, if_id_parada, if_id_limpar, id_ex_limpar,
               muldiv_inicia, muldiv_ocupado, contador_bolhas
    );

    // Hazard unit side.
    modport slave (
        input  id_rs, id_rt, id_usa_rs, id_usa_rt,
               id_inicia_mul, id_inicia_div, id_le_hilo,
               ex_le_mem, ex_rt, ex_desvio_tomado,
        output pc_escrita, if_id_parada, if_id_limpar, id_ex_limpar,
               muldiv_inicia, muldiv_ocupado, contador_bolhas
    );

endinterface

// File: rtl/contador_muldiv.sv
// Sequencer for the multi-cycle MULT/DIV unit.
//
//  state    | meaning
//  ---------+-------------------------------------------------------
//  OCIOSO   | unit free, waiting for a start pulse
//  CONTANDO | operation in flight, cnt counts down to 0 then frees
module contador_muldiv
    import mips_pkg::*;
#(
    parameter int LAT_MUL = LAT_MUL_PADRAO,
    parameter int LAT_DIV = LAT_DIV_PADRAO,
    parameter int CONT_W  = $clog2(LAT_DIV + 1)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       is_div,
    output estado_md_t estado,
    output logic       ocupado
);

    estado_md_t        estado_prox;
    logic [CONT_W-1:0] cnt;
    logic [CONT_W-1:0] cnt_prox;

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
        end
    end

    // Next state: a start loads latency-1 so CONTANDO lasts exactly the latency.
    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        case (estado)
            OCIOSO: begin
                if (start) begin
                    estado_prox = CONTANDO;
                    cnt_prox    = is_div ? CONT_W'(LAT_DIV - 1) : CONT_W'(LAT_MUL - 1);
                end
            end
            CONTANDO: begin
                if (cnt != '0) begin
                    cnt_prox = cnt - 1'b1;
                end else begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Busy flag decodes straight from the state register, so it is glitch-free.
    always_comb begin
        ocupado = (estado == CONTANDO);
    end

endmodule

// File: rtl/controle_hazard.sv
// Hazard controller for the 5-stage pipeline: load-use, taken-branch flush
// and MULT/DIV structural stalls, plus a saturating stall-cycle counter.
module controle_hazard
    import mips_pkg::*;
#(
    parameter int LAT_MUL = LAT_MUL_PADRAO,
    parameter int LAT_DIV = LAT_DIV_PADRAO
) (
    input  logic               clock,
    input  logic               reset_n,
    controle_hazard_if.slave   bus
);

    localparam int CONT_W = $clog2(LAT_DIV + 1);

    estado_md_t          estado_md;
    logic                ocupado;
    logic                carga_uso;
    logic                conflito_md;
    logic                para;
    logic                pc_escrita;
    logic                if_id_parada;
    logic                if_id_limpar;
    logic                id_ex_limpar;
    logic                muldiv_inicia;
    logic [BOLHAS_W-1:0] bolhas;

    // Hazard detection; a taken branch squashes ID, so any stall it would cause is moot.
    always_comb begin
        carga_uso   = bus.ex_le_mem && (bus.ex_rt != '0) &&
                      ((bus.id_usa_rs && (bus.id_rs == bus.ex_rt)) ||
                       (bus.id_usa_rt && (bus.id_rt == bus.ex_rt)));
        conflito_md = (estado_md == CONTANDO) &&
                      (bus.id_le_hilo || bus.id_inicia_mul || bus.id_inicia_div);
        para        = (carga_uso || conflito_md) && !bus.ex_desvio_tomado;
    end

    // Pipeline controls, flush over stall over normal advance.
    always_comb begin
        pc_escrita    = 1'b1;
        if_id_parada  = 1'b0;
        if_id_limpar  = 1'b0;
        id_ex_limpar  = 1'b0;
        muldiv_inicia = 1'b0;
        if (bus.ex_desvio_tomado) begin
            if_id_limpar = 1'b1;
            id_ex_limpar = 1'b1;
        end else if (para) begin
            pc_escrita   = 1'b0;
            if_id_parada = 1'b1;
            id_ex_limpar = 1'b1;
        end else begin
            // A start blocked by a stall is simply retried once the stall clears.
            muldiv_inicia = (estado_md == OCIOSO) &&
                            (bus.id_inicia_mul || bus.id_inicia_div);
        end
    end

    // Saturating count of stall cycles; flushes are not stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bolhas <= '0;
        end else if (para && (bolhas != {BOLHAS_W{1'b1}})) begin
            bolhas <= bolhas + 1'b1;
        end
    end

    contador_muldiv #(
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .CONT_W  (CONT_W)
    ) u_contador (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (muldiv_inicia),
        .is_div  (bus.id_inicia_div),
        .estado  (estado_md),
        .ocupado (ocupado)
    );

    assign bus.pc_escrita      = pc_escrita;
    assign bus.if_id_parada    = if_id_parada;
    assign bus.if_id_limpar    = if_id_limpar;
    assign bus.id_ex_limpar    = id_ex_limpar;
    assign bus.muldiv_inicia   = muldiv_inicia;
    assign bus.muldiv_ocupado  = ocupado;
    assign bus.contador_bolhas = bolhas;

endmodule
